fp_dot_seq: RTL and testbench

Sequencer that time-shares one `fp_mul` and one `fp_add` instance (Q16.16 by default) to compute a saturating fixed-point dot product of `len` operand pairs. Pairs arrive on a valid/ready stream. The product is registered and then accumulated. The result and a sticky saturation flag are returned on a valid/ready output. The block sits between the operand fetch logic and the fixed-point primitives and is the only owner of both primitive instances.

---
 rtl/fp_dot_seq.sv | 151 +++++++++++++++
 tb/tb_fp_dot_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_dot_seq.sv
// Saturating fixed-point dot-product sequencer sharing one fp_mul and one fp_add.
// fp_mul rounds half-up at the fraction boundary; both primitives clamp on overflow.

module fp_mul #(
    parameter int WIDTH    = 32,
    parameter int FRACTION = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             sat
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] RND  = PW'(1) << (FRACTION - 1);
    localparam logic signed [PW-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] full;
    logic signed [PW-1:0] shifted;

    always_comb begin
        full    = PW'($signed(a)) * PW'($signed(b));
        shifted = (full + RND) >>> FRACTION;
        sat     = 1'b0;
        y       = shifted[WIDTH-1:0];
        if (shifted > MAXV) begin
            sat = 1'b1;
            y   = MAXV[WIDTH-1:0];
        end else if (shifted < MINV) begin
            sat = 1'b1;
            y   = MINV[WIDTH-1:0];
        end
    end
endmodule

module fp_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             sat
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        sat = sum[WIDTH] ^ sum[WIDTH-1];
        y   = sum[WIDTH-1:0];
        if (sat)
            y = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
endmodule

module fp_dot_seq #(
    parameter int WIDTH    = 32,
    parameter int FRACTION = 16,
    parameter int LEN_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_sat
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] prod_q;
    logic             prod_v;
    logic             prod_sat;
    logic [WIDTH-1:0] acc;
    logic             sat_q;

    logic [WIDTH-1:0] mul_y;
    logic             mul_sat;
    logic [WIDTH-1:0] add_y;
    logic             add_sat;
    logic             accept;

    fp_mul #(.WIDTH(WIDTH), .FRACTION(FRACTION)) u_mul (
        .a(in_a), .b(in_b), .y(mul_y), .sat(mul_sat)
    );

    fp_add #(.WIDTH(WIDTH)) u_add (
        .a(acc), .b(prod_q), .y(add_y), .sat(add_sat)
    );

    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_RUN);
    assign out_valid = (state == S_DONE);
    assign out_y     = acc;
    assign out_sat   = sat_q;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            len_q    <= '0;
            prod_q   <= '0;
            prod_v   <= 1'b0;
            prod_sat <= 1'b0;
            acc      <= '0;
            sat_q    <= 1'b0;
        end else begin
            prod_v <= 1'b0;
            if (accept) begin
                prod_q   <= mul_y;
                prod_sat <= mul_sat;
                prod_v   <= 1'b1;
                cnt      <= cnt + 1'b1;
            end
            if (prod_v) begin
                acc   <= add_y;
                sat_q <= sat_q | prod_sat | add_sat;
            end
            // Job-start clears come last so they win over any stray accumulate.
            case (state)
                S_IDLE: if (start) begin
                    acc   <= '0;
                    sat_q <= 1'b0;
                    if (len != '0) begin
                        len_q <= len;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_RUN:   if (accept && (cnt == len_q - 1'b1)) state <= S_DRAIN;
                S_DRAIN: state <= S_DONE;
                S_DONE:  if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_dot_seq.sv
// Scoreboarded bench for fp_dot_seq: table-driven jobs plus hand-written corner sequences.

module tb_fp_dot_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_sat;

    fp_dot_seq dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc = 0;
    int ov_rise = 0;
    logic ov_prev = 1'b0;
    logic [32:0] exp_q[$];
    logic [31:0] ja[$];
    logic [31:0] jb[$];

    typedef struct {
        int          n;
        int          gap;
        logic [31:0] a[4];
        logic [31:0] b[4];
        logic [31:0] ey;
        logic        es;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are observed mid-cycle; each valid&&ready here completes at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_acc = cyc;
            end
            if (out_valid && !ov_prev) ov_rise = cyc;
            if (out_valid && out_ready) begin
                logic [32:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h/%b expected none", out_y, out_sat);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_y, out_sat} !== e) begin
                        errors++;
                        $display("FAIL result: got y=%h sat=%b expected y=%h sat=%b",
                                 out_y, out_sat, e[32:1], e[0]);
                    end
                end
            end
        end
        ov_prev = rst ? 1'b0 : out_valid;
    end

    function automatic int sat32(input longint v, inout logic s);
        if (v > 64'sd2147483647) begin s = 1'b1; return 32'h7FFFFFFF; end
        if (v < -64'sd2147483648) begin s = 1'b1; return 32'h80000000; end
        return int'(v);
    endfunction

    function automatic logic [32:0] model(input int n);
        longint p;
        int     acc;
        logic   s;
        acc = 0;
        s   = 1'b0;
        for (int i = 0; i < n; i++) begin
            p   = longint'($signed(ja[i])) * longint'($signed(jb[i]));
            p   = (p + 64'sd32768) >>> 16;
            p   = longint'(sat32(p, s));
            acc = sat32(longint'(acc) + p, s);
        end
        return {acc, s};
    endfunction

    task automatic run_job(input int n, input int gap, input logic [31:0] ey, input logic es);
        int t;
        exp_q.push_back({ey, es});
        acc_cnt = 0;
        t = 0;
        while (busy && t < 400) begin @(posedge clk); #1; t++; end
        start = 1'b1;
        len   = n[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 1) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    chk("bubble_ready", in_ready, 1);
                end
            end
            in_valid = 1'b1;
            in_a = ja[i];
            in_b = jb[i];
            t = 0;
            while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("ready_low_after_last", in_ready, 0);
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
        chk("result_timeout", exp_q.size(), 0);
        chk("accept_count", acc_cnt, n);
        if (n > 0) chk("result_latency", ov_rise - last_acc, 2);
    endtask

    vec_t vt[6];

    initial begin
        logic [32:0] m;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;

        // 1.0=0x10000 ; products: 2+2-3=1 ; sat cases clamp at the product
        vt[0] = '{3, 0, '{32'h00010000, 32'h00008000, 32'hFFFE8000, 0}, '{32'h00020000, 32'h00040000, 32'h00020000, 0}, 32'h00010000, 1'b0};
        vt[1] = '{3, 3, '{32'h00010000, 32'h00008000, 32'hFFFE8000, 0}, '{32'h00020000, 32'h00040000, 32'h00020000, 0}, 32'h00010000, 1'b0};
        vt[2] = '{2, 0, '{32'h7FFF0000, 32'hFFFF0000, 0, 0}, '{32'h03E80000, 32'h00010000, 0, 0}, 32'h7FFEFFFF, 1'b1};
        vt[3] = '{1, 0, '{32'h80000000, 0, 0, 0}, '{32'h03E80000, 0, 0, 0}, 32'h80000000, 1'b1};
        vt[4] = '{2, 1, '{32'h00028000, 32'hFFFF4000, 0, 0}, '{32'hFFFEC000, 32'hFFFF8000, 0, 0}, 32'hFFFD4000, 1'b0};
        // partial sum saturates high, then a negative product pulls it back from the clamp
        vt[5] = '{3, 0, '{32'h40000000, 32'h40000000, 32'hFFFF0000, 0}, '{32'h00010000, 32'h00010000, 32'h00010000, 0}, 32'h7FFEFFFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            ja.delete(); jb.delete();
            for (int i = 0; i < vt[v].n; i++) begin
                ja.push_back(vt[v].a[i]);
                jb.push_back(vt[v].b[i]);
            end
            run_job(vt[v].n, vt[v].gap, vt[v].ey, vt[v].es);
        end

        // Zero-length job held under output back-pressure; start during DONE must be ignored.
        out_ready = 1'b0;
        start = 1'b1; len = 8'd0;
        @(posedge clk); #1;
        chk("zl_valid_t1", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd3;
            chk("zl_hold_valid", out_valid, 1);
            chk("zl_hold_y", {out_y, out_sat}, 33'd0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        exp_q.push_back(33'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("zl_idle_busy", busy, 0);
        chk("zl_idle_valid", out_valid, 0);
        chk("zl_drained", exp_q.size(), 0);

        // Reset after the second accept of a 4-pair job.
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_a = 32'h00010000; in_b = 32'h00010000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        ja.delete(); jb.delete();
        ja.push_back(32'h00030000); jb.push_back(32'h00004000);
        run_job(1, 0, 32'h0000C000, 1'b0);

        // Maximum length: 255 * (1.0 * 2^-7).
        ja.delete(); jb.delete();
        for (int i = 0; i < 255; i++) begin
            ja.push_back(32'h00010000);
            jb.push_back(32'h00000200);
        end
        run_job(255, 0, 32'h0001FE00, 1'b0);

        // Random jobs checked against the reference model, mixing small and full-range operands.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 6);
            ja.delete(); jb.delete();
            for (int i = 0; i < n; i++) begin
                if (r == 3) begin
                    ja.push_back($urandom());
                    jb.push_back($urandom());
                end else begin
                    ja.push_back($urandom_range(0, 32'h000FFFFF) - 32'h00080000);
                    jb.push_back($urandom_range(0, 32'h000FFFFF) - 32'h00080000);
                end
            end
            m = model(n);
            run_job(n, r % 2, m[32:1], m[0]);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
